// File: rtl/adder_arbiter_pkg.sv
// rtl/adder_arbiter_pkg.sv - shared defaults, result type and round-robin search helper
package adder_arbiter_pkg;

    localparam int N_DEF       = 9;
    localparam int NUM_REQ_DEF = 4;
    localparam int CNT_W_DEF   = 16;
    localparam int ID_W_DEF    = $clog2(NUM_REQ_DEF);

    typedef struct packed {
        logic [N_DEF-1:0]    sum;
        logic                carry;
        logic [ID_W_DEF-1:0] id;
    } result_t;

    typedef struct packed {
        logic       found;
        logic [7:0] idx;
    } pick_t;

    // First valid requester strictly after ptr, wrapping; ptr itself is tried last.
    function automatic pick_t rr_pick(input logic [31:0] valid,
                                      input logic [31:0] ptr,
                                      input int unsigned num_req);
        pick_t       r;
        int unsigned idx;
        r = '0;
        for (int unsigned k = 1; k <= 32; k++) begin
            idx = ptr + k;
            if (idx >= num_req) begin
                idx = idx - num_req;
            end
            if (k <= num_req && !r.found && valid[idx[4:0]]) begin
                r.found = 1'b1;
                r.idx   = 8'(idx);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_arbiter_rr_arbiter.sv
// rtl/adder_arbiter_rr_arbiter.sv - round-robin grant search with last-winner pointer
module rr_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               update,
    output logic [ID_W-1:0]    grant,
    output logic               found
);

    logic [ID_W-1:0] ptr;
    pick_t           pick;

    always_comb begin
        pick = rr_pick(32'(valid), 32'(ptr), NUM_REQ);
    end

    assign grant = ID_W'(pick.idx);
    assign found = pick.found;

    // Pointer moves only on an accepted request, so a stalled grant keeps priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= ID_W'(NUM_REQ - 1);
        end else if (update) begin
            ptr <= grant;
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin shared adder with two-stage backpressured pipeline
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*N-1:0] req_a,
    input  logic [NUM_REQ*N-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [N-1:0]         rsp_sum,
    output logic                 rsp_carry,
    output logic [ID_W-1:0]      rsp_id,
    output logic [CNT_W-1:0]     op_count
);

    logic            op_valid;
    logic [N-1:0]    op_a;
    logic [N-1:0]    op_b;
    logic [ID_W-1:0] op_id;

    logic            s2_load;
    logic            s1_free;
    logic            hs;
    logic [ID_W-1:0] grant;
    logic            found;
    logic [N-1:0]    sel_a;
    logic [N-1:0]    sel_b;
    logic [N:0]      sum_full;

    assign s2_load = op_valid & (~rsp_valid | rsp_ready);
    assign s1_free = ~op_valid | s2_load;
    assign hs      = found & s1_free;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .clk    (clk),
        .rst    (rst),
        .valid  (req_valid),
        .update (hs),
        .grant  (grant),
        .found  (found)
    );

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = hs && (grant == ID_W'(i));
        end
    end

    always_comb begin
        sel_a = req_a[int'(grant)*N +: N];
        sel_b = req_b[int'(grant)*N +: N];
    end

    // Full-width add so the carry is taken from bit N, never from a truncated sum.
    assign sum_full = {1'b0, op_a} + {1'b0, op_b};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            op_id    <= '0;
        end else if (hs) begin
            op_valid <= 1'b1;
            op_a     <= sel_a;
            op_b     <= sel_b;
            op_id    <= grant;
        end else if (s2_load) begin
            op_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
            rsp_id    <= '0;
        end else if (s2_load) begin
            rsp_valid <= 1'b1;
            rsp_sum   <= sum_full[N-1:0];
            rsp_carry <= sum_full[N];
            rsp_id    <= op_id;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= '0;
        end else if (rsp_valid && rsp_ready && (op_count != {CNT_W{1'b1}})) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - scoreboard bench for adder_arbiter with random and directed traffic
module tb_adder_arbiter;
    import adder_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready, req_ready2;
    logic [35:0] req_a, req_b;
    logic        rsp_ready;
    logic        rsp_valid, rsp_valid2;
    logic [8:0]  rsp_sum, rsp_sum2;
    logic        rsp_carry, rsp_carry2;
    logic [1:0]  rsp_id, rsp_id2;
    logic [15:0] op_count;
    logic [3:0]  op_count2;

    adder_arbiter dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .rsp_id(rsp_id), .op_count(op_count)
    );

    adder_arbiter #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready2),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum2), .rsp_carry(rsp_carry2), .rsp_id(rsp_id2), .op_count(op_count2)
    );

    always #5 clk = ~clk;

    int      checks = 0;
    int      errors = 0;
    result_t exp_q[$];
    int      mptr = 3;
    int      inflight = 0;
    int      completed = 0;
    int      hs_total = 0;
    bit      mon_en = 0;
    bit      hold = 0;
    logic [8:0] prev_sum;
    logic       prev_carry;
    logic [1:0] prev_id;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        mptr = 3;
        inflight = 0;
        completed = 0;
        hold = 0;
    endtask

    task automatic send(input int id, input logic [8:0] a, input logic [8:0] b);
        bit got;
        got = 0;
        req_valid = 4'(1 << id);
        req_a[id*9 +: 9] = a;
        req_b[id*9 +: 9] = b;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (req_ready[id]) got = 1;
        end
        if (!got) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        req_valid = '0;
    endtask

    // Reference: round-robin from last accepted requester; two slots of storage in flight.
    always @(negedge clk) begin : monitor
        int         eidx;
        int         tot;
        logic [3:0] eready;
        result_t    e;
        if (mon_en && !rst) begin
            eidx = -1;
            for (int k = 1; k <= 4; k++) begin
                int j;
                j = (mptr + k) % 4;
                if (eidx < 0 && req_valid[j]) eidx = j;
            end
            eready = (eidx >= 0 && (inflight < 2 || rsp_ready)) ? 4'(1 << eidx) : 4'b0;
            chk("req_ready", req_ready, eready);
            if (hold) begin
                chk("hold_valid", rsp_valid, 1);
                chk("hold_sum", rsp_sum, prev_sum);
                chk("hold_carry", rsp_carry, prev_carry);
                chk("hold_id", rsp_id, prev_id);
            end
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    tot = int'(req_a[i*9 +: 9]) + int'(req_b[i*9 +: 9]);
                    e.sum   = 9'(tot % 512);
                    e.carry = (tot >= 512);
                    e.id    = 2'(i);
                    exp_q.push_back(e);
                    mptr = i;
                    inflight++;
                    hs_total++;
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp actual=id%0d required=none", rsp_id);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_sum", rsp_sum, e.sum);
                    chk("rsp_carry", rsp_carry, e.carry);
                    chk("rsp_id", rsp_id, e.id);
                end
                chk("op_count", op_count, (completed > 65535) ? 65535 : completed);
                chk("op_count_sat", op_count2, (completed > 15) ? 15 : completed);
                completed++;
                inflight--;
            end
            hold       = rsp_valid && !rsp_ready;
            prev_sum   = rsp_sum;
            prev_carry = rsp_carry;
            prev_id    = rsp_id;
        end
    end

    initial begin : stim
        int grants[8];
        int h0;
        rst = 1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_sum", rsp_sum, 0);
        chk("rst_rsp_carry", rsp_carry, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_req_ready", req_ready, 0);
        rst = 0;
        mon_en = 1;

        // Single request with carry into bit 8 but none out of the sum.
        rsp_ready = 1;
        send(2, 9'h0FF, 9'h001);
        step();
        chk("single_valid", rsp_valid, 1);
        chk("single_sum", rsp_sum, 9'h100);
        chk("single_carry", rsp_carry, 0);
        chk("single_id", rsp_id, 2);
        step();
        chk("single_count", op_count, 1);
        chk("single_drained", rsp_valid, 0);

        send(0, 9'h1FF, 9'h001);
        step();
        chk("ovf1_sum", rsp_sum, 9'h000);
        chk("ovf1_carry", rsp_carry, 1);
        send(1, 9'h1FF, 9'h1FF);
        step();
        chk("ovf2_sum", rsp_sum, 9'h1FE);
        chk("ovf2_carry", rsp_carry, 1);

        // Fairness: put the pointer on 3 so requester 0 leads.
        send(3, 9'h011, 9'h022);
        step();
        req_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            req_a = 36'({$urandom(), $urandom()});
            req_b = 36'({$urandom(), $urandom()});
            @(negedge clk);
            grants[c] = -1;
            for (int i = 0; i < 4; i++) if (req_ready[i]) grants[c] = i;
            step();
        end
        req_valid = '0;
        for (int c = 0; c < 8; c++) chk("fair_grant", grants[c], c % 4);
        repeat (3) step();

        // Backpressure fills both stages then blocks all requesters.
        h0 = hs_total;
        rsp_ready = 0;
        req_valid = 4'b0011;
        repeat (6) step();
        chk("bp_handshakes", hs_total - h0, 2);
        @(negedge clk);
        chk("bp_req_ready", req_ready, 0);
        chk("bp_rsp_valid", rsp_valid, 1);
        step();
        req_valid = '0;
        rsp_ready = 1;
        repeat (4) step();
        chk("bp_drained", exp_q.size(), 0);

        // Reset with both stages full.
        rsp_ready = 0;
        req_valid = 4'b0011;
        repeat (4) step();
        req_valid = '0;
        @(negedge clk);
        #2;
        rst = 1;
        #1;
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_op_count", op_count, 0);
        chk("midrst_op_count_sat", op_count2, 0);
        model_reset();
        @(posedge clk);
        #3;
        rst = 0;
        req_valid = 4'b1001;
        rsp_ready = 1;
        @(negedge clk);
        chk("post_rst_first", req_ready, 4'b0001);
        step();
        req_valid = '0;
        repeat (2) step();

        // Random traffic with random backpressure and request drops.
        for (int c = 0; c < 400; c++) begin
            req_valid = 4'($urandom());
            req_a = 36'({$urandom(), $urandom()});
            req_b = 36'({$urandom(), $urandom()});
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        req_valid = '0;
        rsp_ready = 1;
        repeat (5) step();
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_count", op_count, completed);
        chk("final_sat", op_count2, (completed > 15) ? 15 : completed);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
